traffic_sched: RTL
==================

# traffic_sched

Central traffic scheduler for the road lanes of the game. Replaces the free-running speed counter in each car controller. Generates one registered move strobe per lane from a shared base-tick prescaler and per-lane period counters. Owns the difficulty level and the post-collision freeze state. Sits between the game-state logic (collision, goal detection) and the per-lane car controllers; car controllers step one pixel per strobe in the direction given by `o_Direction`.

## Interface
- `c_NUM_LANES`, 4: number of lanes served, 1..8.
- `c_BASE_TICK`, 165000: i_Clk cycles per base tick, ≥2.
- `c_LANE_PERIODS`, {8'd8,8'd12,8'd6,8'd10}: packed 8-bit level-0 period per lane in base ticks; lane 0 in bits [7:0]; each value ≥1.
- `c_LANE_DIRS`, 4'b1010: per-lane direction, bit l drives `o_Direction[l]` (0 = right, 1 = left).
- `c_LEVEL_STEP`, 1: base ticks removed from every lane period per level.
- `c_MIN_PERIOD`, 2: floor on effective lane period, ≥1.
- `c_MAX_LEVEL`, 7: level saturation value, ≤7.
- `c_FREEZE_TICKS`, 150: base ticks spent in PAUSE after a collision, ≥1.

Ports:
- `i_Clk` in 1: system clock.
- `i_Rst_n` in 1: asynchronous active-low reset.
- `i_Game_Active` in 1: level-sensitive; low forces IDLE.
- `i_Level_Up` in 1: one-cycle pulse, frog reached far bank.
- `i_Collision` in 1: one-cycle pulse, frog hit by a car.
- `o_Move_Tick` out c_NUM_LANES: one-cycle move strobe per lane.
- `o_Direction` out c_NUM_LANES: lane directions, constant `c_LANE_DIRS`.
- `o_Level` out 3: current level.
- `o_Freeze` out 1: high while in PAUSE.

## Operation
- FSM states: IDLE, RUN, PAUSE.
  - IDLE → RUN when `i_Game_Active`=1.
  - RUN → PAUSE on `i_Collision`.
  - PAUSE → RUN after `c_FREEZE_TICKS` base ticks.
  - Any state → IDLE when `i_Game_Active`=0, same cycle, with priority over all other events.
- In IDLE, all of the following are held at 0: prescaler, lane counters, freeze counter, level.
- Prescaler:
  - Counts 0..c_BASE_TICK-1 in RUN and PAUSE.
  - An internal base-tick pulse fires on the cycle the count equals c_BASE_TICK-1; the count wraps to 0 on that cycle.
- Effective period P_l = max(c_MIN_PERIOD, base_l − o_Level·c_LEVEL_STEP).
  - Compute at 9-bit signed width so underflow clamps to c_MIN_PERIOD instead of wrapping.
- Lane counters (8-bit) advance only in RUN.
  - On a base tick, if cnt_l == P_l−1: cnt_l ← 0 and `o_Move_Tick[l]` ← 1 next cycle.
  - Otherwise cnt_l ← cnt_l+1.
- `i_Level_Up` in RUN:
  - o_Level ← min(o_Level+1, c_MAX_LEVEL).
  - All lane counters and the prescaler clear to 0.
  - Ignored in IDLE and PAUSE.
- `i_Collision` in RUN: enter PAUSE, clear the freeze counter. Lane counters hold their values and the prescaler keeps running.
- Collision and level-up in the same cycle: collision wins, level-up is dropped.
- Collision while already in PAUSE: ignored; the freeze counter is not restarted.

## Timing
- Reset values: `o_Move_Tick`=0, `o_Level`=0, `o_Freeze`=0, FSM=IDLE, all counters 0.
- `o_Direction` equals `c_LANE_DIRS` at all times, including during reset.
- All other outputs are registered.
- `o_Move_Tick[l]` is high exactly one cycle, on the cycle after the base-tick pulse that wraps cnt_l.
- First strobe after entering RUN from IDLE: lane l fires at cycle P_l·c_BASE_TICK+1, counted from the first RUN cycle.
- `o_Freeze` rises the cycle after `i_Collision`. It falls the cycle after the c_FREEZE_TICKS-th base tick in PAUSE. No move strobes are issued while `o_Freeze`=1.
- `o_Level` updates the cycle after `i_Level_Up`. The new P_l applies from that cycle.
- Deasserting `i_Game_Active` mid-strobe: `o_Move_Tick` is 0 from the next cycle.
- Asserting `i_Rst_n` low clears everything immediately, independent of the clock.

## Configuration
- `TRAFFIC_SCHED_PAUSE_EN`:
  - Defined: PAUSE state, freeze counter and `o_Freeze` behave as above.
  - Undefined: `i_Collision` is ignored and the FSM never leaves RUN except to IDLE. `o_Freeze` is tied to 0, and PAUSE logic and `c_FREEZE_TICKS` are unused.

## Test plan
Bench uses c_BASE_TICK=4, c_LANE_PERIODS={8'd1,8'd2,8'd5,8'd3}, c_MIN_PERIOD=2, c_FREEZE_TICKS=2, macro defined unless stated.
- Reset then `i_Game_Active`=1 → lane0 strobes every 12 cycles, first at cycle 13. Lane1 strobes every 20 cycles and lane2 every 8, single-cycle wide. Lane3 clamps to period 2 and strobes every 8.
- Five `i_Level_Up` pulses → `o_Level`=5. Lane0 period is 2 (3−5 clamped); all lanes strobe every 8 cycles. Counters restart on each pulse.
- Eight further `i_Level_Up` pulses → `o_Level` saturates at 7, no wrap.
- `i_Collision` in RUN → `o_Freeze`=1 next cycle and stays high 8 cycles (±prescaler phase). No strobes during that time. Lane counters resume from their held values.
- `i_Collision` and `i_Level_Up` in the same cycle → PAUSE entered, `o_Level` unchanged. Separately: drop `i_Game_Active` during PAUSE → IDLE, `o_Freeze`=0, `o_Level`=0.
- Macro undefined, `i_Collision` pulsed → strobe cadence unchanged, `o_Freeze` stays 0.

Source files
------------

// File: rtl/traffic_sched.sv
// traffic_sched - central move-strobe scheduler for the road lanes.
//
// A shared prescaler produces a base tick every c_BASE_TICK clocks. Each lane
// owns an 8-bit period counter that wraps after P_l base ticks, where
// P_l = max(c_MIN_PERIOD, base_l - level*c_LEVEL_STEP). The wrap is reported
// one cycle later as a single-cycle strobe on o_Move_Tick[l].
//
// Build option: define TRAFFIC_SCHED_PAUSE_EN to enable the post-collision
// freeze (PAUSE state, freeze counter, o_Freeze). Without it, collisions are
// ignored and o_Freeze is tied low.
//
// Ports:
//   i_Clk          system clock
//   i_Rst_n        asynchronous active-low reset
//   i_Game_Active  level; low forces IDLE and clears all state
//   i_Level_Up     pulse; raise difficulty (RUN only), restart lane timing
//   i_Collision    pulse; freeze traffic (RUN only, PAUSE build)
//   o_Move_Tick    per-lane single-cycle move strobe
//   o_Direction    per-lane direction, constant c_LANE_DIRS (1 = left)
//   o_Level        current difficulty level
//   o_Freeze       high while frozen after a collision
//
// state | meaning
// IDLE  | game inactive, everything held at zero
// RUN   | traffic moving, lanes advance on base ticks
// PAUSE | post-collision freeze, prescaler runs, lanes hold
module traffic_sched #(
  parameter int                         c_NUM_LANES    = 4,
  parameter int                         c_BASE_TICK    = 165000,
  parameter logic [8*c_NUM_LANES-1:0]   c_LANE_PERIODS = {8'd8, 8'd12, 8'd6, 8'd10},
  parameter logic [c_NUM_LANES-1:0]     c_LANE_DIRS    = 4'b1010,
  parameter int                         c_LEVEL_STEP   = 1,
  parameter int                         c_MIN_PERIOD   = 2,
  parameter int                         c_MAX_LEVEL    = 7,
  parameter int                         c_FREEZE_TICKS = 150
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Game_Active,
  input  logic                   i_Level_Up,
  input  logic                   i_Collision,
  output logic [c_NUM_LANES-1:0] o_Move_Tick,
  output logic [c_NUM_LANES-1:0] o_Direction,
  output logic [2:0]             o_Level,
  output logic                   o_Freeze
);

  localparam int                 PRESC_W    = (c_BASE_TICK > 2) ? $clog2(c_BASE_TICK) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(c_BASE_TICK - 1);
  localparam logic [2:0]         MAX_LVL    = 3'(c_MAX_LEVEL);
  localparam logic [7:0]         MIN_P      = 8'(c_MIN_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t                 state_q, state_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [2:0]             level_q, level_d;
  logic [c_NUM_LANES-1:0] move_q, move_d;
  logic [7:0]             cnt_q [c_NUM_LANES];
  logic [7:0]             cnt_d [c_NUM_LANES];
  logic                   base_tick;
  logic                   clr;

`ifdef TRAFFIC_SCHED_PAUSE_EN
  localparam int               FRZ_W    = (c_FREEZE_TICKS > 1) ? $clog2(c_FREEZE_TICKS) : 1;
  localparam logic [FRZ_W-1:0] FRZ_LAST = FRZ_W'(c_FREEZE_TICKS - 1);
  logic [FRZ_W-1:0] frz_q, frz_d;
  logic             freeze_q;
`else
  logic unused_pause_cfg;
  assign unused_pause_cfg = i_Collision ^ (c_FREEZE_TICKS > 0);
`endif

  // Signed 9-bit difference so a large level clamps to the floor instead of wrapping.
  function automatic logic [7:0] eff_period(input logic [7:0] base, input logic [2:0] lvl);
    logic signed [8:0] diff;
    diff = $signed({1'b0, base}) - $signed({6'd0, lvl} * 9'(c_LEVEL_STEP));
    if (diff < $signed({1'b0, MIN_P})) eff_period = MIN_P;
    else                               eff_period = 8'(diff);
  endfunction

  assign base_tick = (state_q != S_IDLE) && (presc_q == PRESC_LAST);
  assign clr       = !i_Game_Active || (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    move_d  = '0;
`ifdef TRAFFIC_SCHED_PAUSE_EN
    frz_d   = frz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_Game_Active) state_d = S_RUN;
      end
      S_RUN: begin
        presc_d = base_tick ? '0 : presc_q + 1'b1;
`ifdef TRAFFIC_SCHED_PAUSE_EN
        // Collision beats a simultaneous level-up; lanes hold their counts.
        if (i_Collision) begin
          state_d = S_PAUSE;
          frz_d   = '0;
        end else
`endif
        if (i_Level_Up) begin
          level_d = (level_q >= MAX_LVL) ? MAX_LVL : level_q + 3'd1;
          presc_d = '0;
          for (int l = 0; l < c_NUM_LANES; l++) cnt_d[l] = '0;
        end else if (base_tick) begin
          for (int l = 0; l < c_NUM_LANES; l++) begin
            if (cnt_q[l] == eff_period(c_LANE_PERIODS[8*l +: 8], level_q) - 8'd1) begin
              cnt_d[l]  = '0;
              move_d[l] = 1'b1;
            end else begin
              cnt_d[l] = cnt_q[l] + 8'd1;
            end
          end
        end
      end
`ifdef TRAFFIC_SCHED_PAUSE_EN
      S_PAUSE: begin
        presc_d = base_tick ? '0 : presc_q + 1'b1;
        if (base_tick) begin
          if (frz_q == FRZ_LAST) begin
            state_d = S_RUN;
            frz_d   = '0;
          end else begin
            frz_d = frz_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Inactive game wins over everything; IDLE keeps all timing state at zero.
    if (clr) begin
      presc_d = '0;
      level_d = '0;
      move_d  = '0;
      for (int l = 0; l < c_NUM_LANES; l++) cnt_d[l] = '0;
`ifdef TRAFFIC_SCHED_PAUSE_EN
      frz_d   = '0;
`endif
    end
    if (!i_Game_Active) state_d = S_IDLE;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      level_q <= '0;
      move_q  <= '0;
      for (int l = 0; l < c_NUM_LANES; l++) cnt_q[l] <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      level_q <= level_d;
      move_q  <= move_d;
      for (int l = 0; l < c_NUM_LANES; l++) cnt_q[l] <= cnt_d[l];
    end
  end

`ifdef TRAFFIC_SCHED_PAUSE_EN
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      frz_q    <= '0;
      freeze_q <= 1'b0;
    end else begin
      frz_q    <= frz_d;
      freeze_q <= (state_d == S_PAUSE);
    end
  end
  assign o_Freeze = freeze_q;
`else
  assign o_Freeze = 1'b0;
`endif

  assign o_Move_Tick = move_q;
  assign o_Direction = c_LANE_DIRS;
  assign o_Level     = level_q;

endmodule
